// File: rtl/payout_controller_if.sv
// Request/drive bundle between the vending FSM side and the payout back end.
// PAYOUT_STATS_EN adds the notes_paid statistic to the bundle.
interface payout_controller_if;
    logic        dispense;
    logic [1:0]  retChange;
    logic        note_ack;
    logic        fault_clr;
    logic        vend_motor;
    logic        eject;
    logic        busy;
    logic        fault;
    logic        err_ovf;
`ifdef PAYOUT_STATS_EN
    logic [15:0] notes_paid;

    modport master (output dispense, retChange, note_ack, fault_clr,
                    input  vend_motor, eject, busy, fault, err_ovf, notes_paid);
    modport slave  (input  dispense, retChange, note_ack, fault_clr,
                    output vend_motor, eject, busy, fault, err_ovf, notes_paid);
`else
    modport master (output dispense, retChange, note_ack, fault_clr,
                    input  vend_motor, eject, busy, fault, err_ovf);
    modport slave  (input  dispense, retChange, note_ack, fault_clr,
                    output vend_motor, eject, busy, fault, err_ovf);
`endif
endinterface

// File: rtl/payout_controller.sv
// Vending payout back end: buffers vends/owed change, runs the motor and note ejector.
// PAYOUT_STATS_EN adds a wrapping 16-bit count of acked notes (notes_paid).
module payout_controller #(
    parameter int VEND_CYCLES   = 50,
    parameter int EJECT_TIMEOUT = 200,
    parameter int GAP_CYCLES    = 10,
    parameter int OWE_W         = 4,
    parameter int VEND_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    payout_controller_if.slave pif
);
    // state | meaning
    // IDLE  | pick next job: vend before change
    // VEND  | motor on for VEND_CYCLES
    // EJECT | ejector on until note_ack or timeout
    // GAP   | all drives low for GAP_CYCLES
    // FAULT | eject timed out; wait for fault_clr
    typedef enum logic [2:0] {IDLE, VEND, EJECT, GAP, FAULT} state_t;

    localparam int T_MAX0 = (VEND_CYCLES > GAP_CYCLES) ? VEND_CYCLES : GAP_CYCLES;
    localparam int T_MAX  = (T_MAX0 > EJECT_TIMEOUT) ? T_MAX0 : EJECT_TIMEOUT;
    localparam int TMR_W  = $clog2(T_MAX + 1);

    localparam logic [VEND_W:0] VEND_MAX = {1'b0, {VEND_W{1'b1}}};
    localparam logic [OWE_W:0]  OWE_MAX  = {1'b0, {OWE_W{1'b1}}};

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [VEND_W-1:0]  vend_pend_q, vend_pend_d;
    logic [OWE_W-1:0]   owed_q, owed_d;
    logic               vend_motor_q, vend_motor_d;
    logic               eject_q, eject_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic               err_ovf_q, err_ovf_d;
    logic               vend_dec, owed_dec;
    logic [VEND_W:0]    vend_sum;
    logic [OWE_W:0]     owed_sum;
`ifdef PAYOUT_STATS_EN
    logic [15:0]        notes_paid_q, notes_paid_d;
`endif

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        vend_motor_d = vend_motor_q;
        eject_d      = eject_q;
        fault_d      = fault_q;
        vend_dec     = 1'b0;
        owed_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (vend_pend_q != '0) begin
                    state_d      = VEND;
                    vend_dec     = 1'b1;
                    tmr_d        = TMR_W'(VEND_CYCLES - 1);
                    vend_motor_d = 1'b1;
                end else if (owed_q != '0) begin
                    state_d = EJECT;
                    tmr_d   = TMR_W'(EJECT_TIMEOUT - 1);
                    eject_d = 1'b1;
                end
            end
            VEND: begin
                if (tmr_q == '0) begin
                    state_d      = GAP;
                    tmr_d        = TMR_W'(GAP_CYCLES - 1);
                    vend_motor_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            EJECT: begin
                if (pif.note_ack) begin
                    owed_dec = 1'b1;
                    eject_d  = 1'b0;
                    state_d  = GAP;
                    tmr_d    = TMR_W'(GAP_CYCLES - 1);
                end else if (tmr_q == '0) begin
                    // Note is still owed; it is retried once the fault is cleared.
                    eject_d = 1'b0;
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            FAULT: begin
                if (pif.fault_clr) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                vend_motor_d = 1'b0;
                eject_d      = 1'b0;
                fault_d      = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Intake and service decrement net out in one add; a decrement only
        // happens with a nonzero count, so no underflow is possible.
        vend_sum = {1'b0, vend_pend_q} + (VEND_W+1)'(pif.dispense) - (VEND_W+1)'(vend_dec);
        owed_sum = {1'b0, owed_q} + (OWE_W+1)'(pif.retChange) - (OWE_W+1)'(owed_dec);

        err_ovf_d = err_ovf_q;
        if (vend_sum > VEND_MAX) begin
            vend_pend_d = VEND_MAX[VEND_W-1:0];
            err_ovf_d   = 1'b1;
        end else begin
            vend_pend_d = vend_sum[VEND_W-1:0];
        end
        if (owed_sum > OWE_MAX) begin
            owed_d    = OWE_MAX[OWE_W-1:0];
            err_ovf_d = 1'b1;
        end else begin
            owed_d = owed_sum[OWE_W-1:0];
        end
`ifdef PAYOUT_STATS_EN
        notes_paid_d = notes_paid_q + 16'(owed_dec);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            vend_pend_q  <= '0;
            owed_q       <= '0;
            vend_motor_q <= 1'b0;
            eject_q      <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            err_ovf_q    <= 1'b0;
`ifdef PAYOUT_STATS_EN
            notes_paid_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            vend_pend_q  <= vend_pend_d;
            owed_q       <= owed_d;
            vend_motor_q <= vend_motor_d;
            eject_q      <= eject_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            err_ovf_q    <= err_ovf_d;
`ifdef PAYOUT_STATS_EN
            notes_paid_q <= notes_paid_d;
`endif
        end
    end

    assign pif.vend_motor = vend_motor_q;
    assign pif.eject      = eject_q;
    assign pif.busy       = busy_q;
    assign pif.fault      = fault_q;
    assign pif.err_ovf    = err_ovf_q;
`ifdef PAYOUT_STATS_EN
    assign pif.notes_paid = notes_paid_q;
`endif

endmodule
